keypad_reader: RTL and testbench
================================

KEYPAD_READER -- requirements
Module: keypad_reader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a level change (5 ms at 50 MHz); legal range 1..2^20-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
REQ-004 btn_n  input  4  raw push-buttons, active-low, asynchronous to clk, bouncy.
REQ-005 keypresses  output  4  debounced key levels, active-high, bit i = key i held.
REQ-006 press_pulse  output  4  one-cycle pulse per key on debounced press (0->1 of keypresses[i]).
REQ-007 key_valid  output  1  event queue non-empty; key_code is meaningful.
REQ-008 key_code  output  2  index of oldest queued press event.
REQ-009 key_ready  input  1  consumer accepts head event when key_valid && key_ready.
REQ-010 clr_ovf  input  1  clears overflow when high.
REQ-011 overflow  output  1  sticky: a press event was lost.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchronizer and be inverted to active-high before use.
REQ-013 Per key: a debounce counter SHALL increment each cycle the synchronized level differs from keypresses[i] and SHALL clear to 0 on any cycle they match.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, keypresses[i] SHALL toggle at that edge and the counter SHALL clear.
REQ-015 Latency: with raw input held clean, keypresses[i] changes exactly 2+DEBOUNCE_CYCLES edges after the first edge sampling the new raw level; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-016 press_pulse[i] SHALL be high in exactly the cycle keypresses[i] first reads 1; releases SHALL generate no pulse or event.
REQ-017 A pending[3:0] register SHALL set bit i at the edge following press_pulse[i].
REQ-018 Each cycle, if the queue can accept a push, the lowest-index set pending bit SHALL be pushed as key_code and cleared at the same edge; one push per cycle maximum.
REQ-019 Simultaneous presses SHALL be queued in ascending key index, one per cycle.
REQ-020 Press-to-valid latency on an empty queue SHALL be 2 cycles (press_pulse at T, key_valid at T+2).
REQ-021 Queue: 4-entry FIFO, occupancy 0..4; key_valid = (occupancy != 0); key_code = head entry, held stable while key_valid && !key_ready.
REQ-022 Pop SHALL occur on an edge with key_valid && key_ready; key_ready while empty SHALL be ignored.
REQ-023 Push is allowed when occupancy < 4, or when occupancy = 4 and a pop occurs the same cycle; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 When full with no pop, pending bits SHALL hold (back-pressure, no loss).
REQ-025 If press_pulse[i] occurs while pending[i] is already set, the event SHALL be dropped and overflow SHALL set at the next edge.
REQ-026 clr_ovf SHALL clear overflow at the next edge; if a new drop occurs in the same cycle, set SHALL win.
REQ-027 FIFO read/write pointers SHALL wrap modulo 4.

Reset
REQ-028 While rst_n low at an edge: synchronizers, counters, pending, and FIFO pointers/occupancy SHALL clear; keypresses=0, press_pulse=0, key_valid=0, key_code=0, overflow=0.
REQ-029 Reset mid-debounce or with a queue non-empty SHALL discard all state; a button held through reset SHALL produce a press event 2+DEBOUNCE_CYCLES cycles after release of reset.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean press: btn_n[2] 1->0 held -> keypresses=4'b0100 and press_pulse[2] at edge 6; key_valid=1 and key_code=2 two cycles later; key_ready=1 -> key_valid=0 next cycle.
REQ-031 Bounce: btn_n[0] low 3 cycles, high 1 cycle, then low held -> no change until 6 edges after final fall; exactly one event, key_code=0.
REQ-032 Simultaneous: btn_n=4'b0000 in one cycle, key_ready=0 -> queue holds codes 0,1,2,3 in that order on consecutive pushes; occupancy 4; overflow=0.
REQ-033 Full plus back-pressure: queue full, key_ready=0, press key 1 again after release -> pending[1] holds; pop once -> code 1 enters queue; no loss.
REQ-034 Overflow: pending[3] set while queue full, key 3 released and re-pressed -> overflow=1; clr_ovf pulse -> overflow=0 next edge.
REQ-035 Reset mid-operation: rst_n low with 3 queued events and a counter mid-count -> all outputs 0 next edge; held key re-reported after 6 cycles.

Source files
------------

// File: rtl/keypad_reader.sv
// Four-key debounced keypad reader: synchronizes and debounces raw active-low buttons,
// reports press events through a 4-entry FIFO, and flags any press event that is lost.
module keypad_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [3:0] keypresses,
    output logic [3:0] press_pulse,
    output logic       key_valid,
    output logic [1:0] key_code,
    input  logic       key_ready,
    input  logic       clr_ovf,
    output logic       overflow
);

    localparam int          CW   = 20;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1, sync2;
    logic [CW-1:0] cnt [4];
    logic [3:0]    toggle;

    logic [1:0]    mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic [3:0]    pending;
    logic [3:0]    pending_next;
    logic [3:0]    push_sel;
    logic [3:0]    drop;
    logic [1:0]    push_code;
    logic          pop, push, can_push;

    // The synchronizer carries the inverted (active-high) level, so its reset value
    // means "released" and a key held through reset is re-detected afterwards.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            toggle[i] = (sync2[i] != keypresses[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            keypresses  <= '0;
            press_pulse <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
            sync1       <= ~btn_n;
            sync2       <= sync1;
            keypresses  <= keypresses ^ toggle;
            press_pulse <= toggle & ~keypresses;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == keypresses[i] || toggle[i]) cnt[i] <= '0;
                else                                        cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Lowest-index pending key wins the single push slot each cycle.
    always_comb begin
        push_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) push_code = 2'(i);
        end
        push_sel     = pending & (~pending + 4'd1);
        key_valid    = (count != 3'd0);
        key_code     = key_valid ? mem[rd_ptr] : 2'd0;
        pop          = key_valid && key_ready;
        can_push     = (count != 3'd4) || pop;
        push         = can_push && (pending != 4'd0);
        drop         = press_pulse & pending;
        pending_next = (pending & ~(push ? push_sel : 4'd0)) | (press_pulse & ~pending);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
            if (drop != 4'd0) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // NOTE: FIFO storage is not reset; key_code is masked by key_valid and pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_code;
    end

endmodule

// File: tb/tb_keypad_reader.sv
// Scoreboard bench for keypad_reader with DEBOUNCE_CYCLES=4: expected key codes are queued
// when presses are driven and compared as the DUT hands events out.
module tb_keypad_reader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] keypresses, press_pulse;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       overflow;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] sb [$];

    keypad_reader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .keypresses(keypresses),
        .press_pulse(press_pulse), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .clr_ovf(clr_ovf), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pops n events, comparing each head against the scoreboard; waits are bounded.
    task automatic drain(input int n, input string name);
        logic [1:0] exp;
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 20;
            while (!key_valid && budget > 0) begin
                tick();
                budget--;
            end
            tests_run++;
            if (!key_valid) begin
                tests_failed++;
                $display("FAIL %s_timeout: key_valid=%b expected 1", name, key_valid);
            end else if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL %s_extra: got code %0d, expected no event", name, key_code);
            end else begin
                exp = sb.pop_front();
                if (key_code !== exp) begin
                    tests_failed++;
                    $display("FAIL %s_code: got %0d expected %0d", name, key_code, exp);
                end
            end
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
        end
    endtask

    task automatic release_all();
        btn_n = 4'hF;
        tick(D + 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_n = 4'hF;
        tick(3);
        tests_run++;
        if ({keypresses, press_pulse, key_valid, key_code, overflow} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got kp=%b pp=%b v=%b code=%0d ovf=%b expected all 0",
                     keypresses, press_pulse, key_valid, key_code, overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean_press();
        logic [3:0] seen;
        btn_n = 4'b1011;
        tick(D + 1);
        tests_run++;
        if (keypresses !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clean_early: keypresses=%b expected 0000", keypresses);
        end
        tick();
        tests_run++;
        if (keypresses !== 4'b0100 || press_pulse !== 4'b0100) begin
            tests_failed++;
            $display("FAIL clean_level: kp=%b pp=%b expected 0100/0100", keypresses, press_pulse);
        end
        sb.push_back(2'd2);
        tick();
        tests_run++;
        if (press_pulse !== 4'b0000 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_t1: pp=%b valid=%b expected 0000/0", press_pulse, key_valid);
        end
        tick();
        tests_run++;
        if (key_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_latency: valid=%b expected 1", key_valid);
        end
        drain(1, "clean");
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_pop: valid=%b expected 0", key_valid);
        end
        key_ready = 1'b1;
        tick(2);
        key_ready = 1'b0;
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_empty: valid=%b expected 0", key_valid);
        end
        btn_n = 4'hF;
        seen = '0;
        for (int k = 0; k < D + 4; k++) begin
            tick();
            seen |= press_pulse;
        end
        tests_run++;
        if (seen !== 4'b0000 || keypresses !== 4'b0000 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_no_event: pulses=%b kp=%b valid=%b expected 0000/0000/0",
                     seen, keypresses, key_valid);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seen;
        seen = '0;
        btn_n = 4'b1110;
        for (int k = 0; k < 3; k++) begin tick(); seen |= keypresses | press_pulse; end
        btn_n = 4'b1111;
        tick();
        seen |= keypresses | press_pulse;
        btn_n = 4'b1110;
        for (int k = 0; k < D + 1; k++) begin tick(); seen |= keypresses | press_pulse; end
        tests_run++;
        if (seen !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bounce_glitch: saw %b expected 0000", seen);
        end
        tick();
        tests_run++;
        if (keypresses !== 4'b0001 || press_pulse !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bounce_accept: kp=%b pp=%b expected 0001/0001", keypresses, press_pulse);
        end
        sb.push_back(2'd0);
        drain(1, "bounce");
        tick(4);
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_single: valid=%b expected 0", key_valid);
        end
        release_all();
    endtask

    task automatic test_simultaneous();
        key_ready = 1'b0;
        btn_n = 4'b0000;
        tick(D + 2);
        tests_run++;
        if (keypresses !== 4'hF || press_pulse !== 4'hF) begin
            tests_failed++;
            $display("FAIL simul_pulse: kp=%b pp=%b expected 1111/1111", keypresses, press_pulse);
        end
        for (int k = 0; k < 4; k++) sb.push_back(2'(k));
        tick(2);
        tests_run++;
        if (key_valid !== 1'b1 || key_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL simul_head: valid=%b code=%0d expected 1/0", key_valid, key_code);
        end
        tick(3);
        tests_run++;
        if (overflow !== 1'b0 || key_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL simul_full: ovf=%b code=%0d expected 0/0", overflow, key_code);
        end
    endtask

    task automatic test_backpressure();
        btn_n = 4'b0010;
        tick(D + 2);
        tests_run++;
        if (keypresses !== 4'b1101) begin
            tests_failed++;
            $display("FAIL bp_release: kp=%b expected 1101", keypresses);
        end
        btn_n = 4'b0000;
        tick(D + 2);
        tests_run++;
        if (press_pulse !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_repress: pp=%b expected 0010", press_pulse);
        end
        sb.push_back(2'd1);
        tick(4);
        tests_run++;
        if (key_code !== 2'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: code=%0d ovf=%b expected 0/0", key_code, overflow);
        end
        drain(5, "bp");
        tick(3);
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: valid=%b expected 0", key_valid);
        end
        release_all();
    endtask

    task automatic test_overflow();
        btn_n = 4'b0000;
        tick(2 * D + 4);
        for (int k = 0; k < 4; k++) sb.push_back(2'(k));
        btn_n = 4'b1000;
        tick(D + 2);
        btn_n = 4'b0000;
        tick(D + 2);
        sb.push_back(2'd3);
        btn_n = 4'b1000;
        tick(D + 2);
        btn_n = 4'b0000;
        tick(D + 2);
        tests_run++;
        if (press_pulse !== 4'b1000 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_before: pp=%b ovf=%b expected 1000/0", press_pulse, overflow);
        end
        tick();
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: ovf=%b expected 1", overflow);
        end
        tick(2);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
        drain(5, "ovf");
        tick(3);
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_empty: valid=%b expected 0 (dropped event must not appear)", key_valid);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        btn_n = 4'b1000;
        tick(D + 7);
        tests_run++;
        if (key_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_queued: valid=%b expected 1", key_valid);
        end
        btn_n = 4'b0000;
        tick(3);
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({keypresses, press_pulse, key_valid, key_code, overflow} !== 12'd0) begin
            tests_failed++;
            $display("FAIL rmid_outputs: kp=%b pp=%b v=%b code=%0d ovf=%b expected all 0",
                     keypresses, press_pulse, key_valid, key_code, overflow);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick(D + 1);
        tests_run++;
        if (keypresses !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rmid_early: kp=%b expected 0000", keypresses);
        end
        tick();
        tests_run++;
        if (keypresses !== 4'hF || press_pulse !== 4'hF) begin
            tests_failed++;
            $display("FAIL rmid_rereport: kp=%b pp=%b expected 1111/1111", keypresses, press_pulse);
        end
        for (int k = 0; k < 4; k++) sb.push_back(2'(k));
        drain(4, "rmid");
        tick(3);
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_empty: valid=%b expected 0", key_valid);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_left: %0d events outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
